// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 load/store unit: op codes, FSM states
// and the legal-op decoder.
package ysyx_25020047_pkg;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic: store replication and byte enables, load byte/half
// selection with sign/zero extension, and alignment check.
module ysyx_25020047_lsu_align (
    input  logic [3:0]  op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ldata,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{ea_lo, 3'b000} +: 8];
        half_sel   = rdata[{ea_lo[1], 4'b0000} +: 16];
        wdata      = rs2;
        wstrb      = '0;
        ldata      = rdata;
        misaligned = 1'b0;
        // op[3] = store, op[2] = unsigned load, op[1:0] = access size
        case (op[1:0])
            2'b00: begin
                wdata = {4{rs2[7:0]}};
                if (op[3]) wstrb = 4'b0001 << ea_lo;
                ldata = op[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wdata      = {2{rs2[15:0]}};
                if (op[3]) wstrb = 4'b0011 << ea_lo;
                ldata      = op[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = ea_lo[0];
            end
            2'b10: begin
                if (op[3]) wstrb = 4'b1111;
                misaligned = |ea_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: single outstanding request over req/gnt/rvalid, result handed
// to writeback over valid/ready. Misaligned and illegal ops bypass memory.
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err
);

    lsu_state_e      state, state_nxt;
    logic [3:0]      op_q;
    logic [1:0]      ea_lo_q;
    logic [XLEN-1:0] ea;
    logic            accept;
    logic            bad;

    logic [3:0]      al_op;
    logic [1:0]      al_ea;
    logic [31:0]     al_wdata;
    logic [3:0]      al_wstrb;
    logic [31:0]     al_ldata;
    logic            al_mis;

    assign ea     = rs1_val + imm;
    assign accept = (state == IDLE) && in_valid;

    // One align instance serves both phases: incoming op while IDLE (store lanes,
    // alignment), the registered op afterwards (load extraction in WAIT).
    assign al_op = (state == IDLE) ? op : op_q;
    assign al_ea = (state == IDLE) ? ea[1:0] : ea_lo_q;

    ysyx_25020047_lsu_align u_align (
        .op         (al_op),
        .ea_lo      (al_ea),
        .rs2        (rs2_val),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .ldata      (al_ldata),
        .misaligned (al_mis)
    );

    assign bad = al_mis || !op_legal(op);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = bad ? RESP : REQ;
            REQ:  if (mem_gnt)    state_nxt = WAIT;
            WAIT: if (mem_rvalid) state_nxt = RESP;
            RESP: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == REQ);
    assign out_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            ea_lo_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            out_rdata <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            op_q      <= op;
            ea_lo_q   <= ea[1:0];
            mem_we    <= op[3] && !bad;
            mem_addr  <= {ea[XLEN-1:2], 2'b00};
            mem_wdata <= al_wdata;
            mem_wstrb <= al_wstrb;
            out_rdata <= '0;
            out_err   <= bad;
        end else if (state == WAIT && mem_rvalid) begin
            out_rdata <= op_q[3] ? '0 : al_ldata;
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed bench for ysyx_25020047_lsu: loads, stores, error path, backpressure
// and asynchronous reset mid-transaction.
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_25020047_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .imm        (imm),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_err    (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full zero-wait transaction with checks at each phase.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] im, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata);
        in_valid = 1'b1; op = o; rs1_val = rs1; rs2_val = rs2; imm = im;
        chk({tag, ".in_ready0"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".req"},   32'(mem_req), 32'd1);
        chk({tag, ".addr"},  mem_addr, exp_addr);
        chk({tag, ".we"},    32'(mem_we), 32'(o[3]));
        chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
        if (o[3]) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        chk({tag, ".in_ready1"}, 32'(in_ready), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
        chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".rdata"},     out_rdata, exp_rdata);
        chk({tag, ".err"},       32'(out_err), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_err(input string tag, input logic [3:0] o, input logic [31:0] rs1,
                          input logic [31:0] im);
        in_valid = 1'b1; op = o; rs1_val = rs1; rs2_val = 32'hFFFF_FFFF; imm = im;
        step();
        in_valid = 1'b0;
        chk({tag, ".req"},       32'(mem_req), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".err"},       32'(out_err), 32'd1);
        chk({tag, ".rdata"},     out_rdata, 32'h0);
        step();
        chk({tag, ".req_hold"},  32'(mem_req), 32'd0);
        chk({tag, ".err_hold"},  32'(out_err), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".done"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; op = 4'd0; rs1_val = '0; rs2_val = '0; imm = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        step(); step();
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.mem_req",   32'(mem_req), 32'd0);
        chk("rst.mem_we",    32'(mem_we), 32'd0);
        chk("rst.mem_addr",  mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_rdata", out_rdata, 32'h0);
        chk("rst.out_err",   32'(out_err), 32'd0);
        @(negedge clk); rst = 1'b1;
        step();

        // Loads: alignment, extension, address wrap
        do_op("lw",      4'd2,  32'h8000_0000, 32'h0, 32'd4, 32'hDEAD_BEEF, 32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF);
        do_op("lb3",     4'd0,  32'h2000, 32'h0, 32'd3, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'hFFFF_FF80);
        do_op("lbu3",    4'd4,  32'h2000, 32'h0, 32'd3, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'h0000_0080);
        do_op("lb1",     4'd0,  32'h2000, 32'h0, 32'd1, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'h0000_007F);
        do_op("lh2",     4'd1,  32'h2000, 32'h0, 32'd2, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'hFFFF_80FF);
        do_op("lhu2",    4'd5,  32'h2000, 32'h0, 32'd2, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'h0000_80FF);
        do_op("lh0",     4'd1,  32'h2000, 32'h0, 32'd0, 32'h80FF_7F01, 32'h2000, 32'h0, 4'h0, 32'h0000_7F01);
        do_op("lw_wrap", 4'd2,  32'hFFFF_FFFC, 32'h0, 32'd8, 32'h1357_9BDF, 32'h0000_0004, 32'h0, 4'h0, 32'h1357_9BDF);

        // Stores: lane replication, byte enables, rdata forced to zero
        do_op("sb",      4'd8,  32'h1000, 32'h1234_5678, 32'd2, 32'hFFFF_FFFF, 32'h1000, 32'h7878_7878, 4'b0100, 32'h0);
        do_op("sh",      4'd9,  32'h1000, 32'h1234_5678, 32'd2, 32'hFFFF_FFFF, 32'h1000, 32'h5678_5678, 4'b1100, 32'h0);
        do_op("sw",      4'd10, 32'h1008, 32'h1234_5678, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1004, 32'h1234_5678, 4'b1111, 32'h0);
        do_op("sb1",     4'd8,  32'h1000, 32'h0000_00A5, 32'd1, 32'h0, 32'h1000, 32'hA5A5_A5A5, 4'b0010, 32'h0);

        // Error path: misaligned and illegal ops never reach memory
        do_err("lw_mis", 4'd2,  32'h1000, 32'd1);
        do_err("illegal3", 4'd3, 32'h1000, 32'd0);
        do_err("lh_mis", 4'd1,  32'h1000, 32'd3);
        do_err("sw_mis", 4'd10, 32'h1000, 32'd2);
        do_err("illegal11", 4'd11, 32'h1000, 32'd0);

        // Backpressure: late grant, idle WAIT cycles, stalled writeback
        in_valid = 1'b1; op = 4'd1; rs1_val = 32'h3000; imm = 32'd2;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp.req",      32'(mem_req), 32'd1);
            chk("bp.addr",     mem_addr, 32'h3000);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            step();
        end
        mem_gnt = 1'b1;
        chk("bp.req_gnt", 32'(mem_req), 32'd1);
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp.wait_req",   32'(mem_req), 32'd0);
            chk("bp.wait_valid", 32'(out_valid), 32'd0);
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_ABCD;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("bp.valid",    32'(out_valid), 32'd1);
            chk("bp.rdata",    out_rdata, 32'h0000_1234);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.done_valid", 32'(out_valid), 32'd0);
        chk("bp.done_ready", 32'(in_ready), 32'd1);

        // rvalid while IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid.valid", 32'(out_valid), 32'd0);
        chk("idle_rvalid.ready", 32'(in_ready), 32'd1);

        // Reset asserted while REQ: mem_req drops without a clock edge
        in_valid = 1'b1; op = 4'd2; rs1_val = 32'h4000; imm = 32'd0;
        step();
        in_valid = 1'b0;
        chk("rst_req.pre", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_req.req",   32'(mem_req), 32'd0);
        chk("rst_req.ready", 32'(in_ready), 32'd1);
        chk("rst_req.addr",  mem_addr, 32'h0);
        @(negedge clk); rst = 1'b1;
        step();

        // Reset asserted while WAIT, rvalid arriving after release
        in_valid = 1'b1; op = 4'd2; rs1_val = 32'h4000; imm = 32'd4;
        step();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rst_wait.pre", 32'(mem_req), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_wait.req",   32'(mem_req), 32'd0);
        chk("rst_wait.ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait.valid", 32'(out_valid), 32'd0);
            chk("rst_wait.rdata", out_rdata, 32'h0);
            chk("rst_wait.idle",  32'(in_ready), 32'd1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
